// File: rtl/div_meas_pkg.sv
// Shared types and defaults for the divided-clock ratio meter.
package div_meas_pkg;
  localparam int CNT_W_DEF    = 16;
  localparam int STABLE_N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE
  } state_t;
endpackage

// File: rtl/edge_sync.sv
// Synchronizes an async level into clk and flags its rising/falling edges.
// Edge pulses appear STAGES edges after the input change; no backpressure.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[STAGES-2:0], sig_in};
      sync_d <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~sync_d;
  assign fall = ~sync[STAGES-1] & sync_d;
endmodule

// File: rtl/div_ratio_meter.sv
// Measures period and high time of a divided clock in clk cycles and flags lock/timeout.
// Result appears SYNC_STAGES+1 edges after the closing rise of sig_in; no backpressure.
module div_ratio_meter
  import div_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_N    = STABLE_N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);
  localparam int                LOCK_W   = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(STABLE_N);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  ht_stage;
  logic [LOCK_W-1:0] lock_cnt;
  logic              first_meas;
  logic              fall_seen;
  logic              rise;
  logic              fall;

  edge_sync #(.STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ht_stage   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      lock_cnt   <= '0;
      first_meas <= 1'b0;
      fall_seen  <= 1'b0;
    end else if (!enable) begin
      // period/high_time deliberately keep their last values
      state      <= IDLE;
      cnt        <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      lock_cnt   <= '0;
      first_meas <= 1'b0;
      fall_seen  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (state == IDLE)        cnt <= '0;
      else if (rise)            cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;

      case (state)
        IDLE: state <= WAIT_FIRST;

        WAIT_FIRST: begin
          if (rise) begin
            state      <= MEASURE;
            first_meas <= 1'b1;
            fall_seen  <= 1'b0;
          end
        end

        MEASURE: begin
          if (rise) begin
            period     <= cnt;
            // no fall observed since the last rise: the whole period was high
            high_time  <= fall_seen ? ht_stage : cnt;
            meas_valid <= 1'b1;
            timeout    <= 1'b0;
            fall_seen  <= 1'b0;
            first_meas <= 1'b0;
            if (first_meas || cnt != period) begin
              lock_cnt <= LOCK_W'(1);
              locked   <= (STABLE_N <= 1);
            end else if (lock_cnt != LOCK_TGT) begin
              lock_cnt <= lock_cnt + 1'b1;
              locked   <= (lock_cnt + 1'b1 >= LOCK_TGT);
            end else begin
              locked   <= 1'b1;
            end
          end else begin
            if (fall) begin
              ht_stage  <= cnt;
              fall_seen <= 1'b1;
            end
            if (cnt == CNT_MAX) begin
              timeout  <= 1'b1;
              locked   <= 1'b0;
              lock_cnt <= '0;
              state    <= WAIT_FIRST;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ratio_meter.sv
// Scoreboard bench: expected period/high/lock pushed at each driven rise, popped on meas_valid.
module tb_div_ratio_meter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig_in;
  logic       enable;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       meas_valid;
  logic       locked;
  logic       timeout;

  div_ratio_meter #(.CNT_W(8), .SYNC_STAGES(2), .STABLE_N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    bit lk;
    int at;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_mv_cyc = 0;
  int   last_per = 0;
  int   last_hi = 0;
  bit   armed = 0;
  bit   run_first = 1;
  int   run_cnt = 0;
  int   prev_h = 0;
  int   prev_l = 0;
  int   model_last_per = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Called at each driven rise; the rise closes the previous cycle's measurement.
  task automatic note_rise(input int h, input int l);
    exp_t e;
    if (armed) begin
      e.per = prev_h + prev_l;
      e.hi  = prev_h;
      if (run_first || e.per != model_last_per) run_cnt = 1;
      else run_cnt++;
      run_first = 0;
      model_last_per = e.per;
      e.lk = (run_cnt >= 4);
      e.at = cyc + 3;
      q.push_back(e);
    end
    armed  = 1;
    prev_h = h;
    prev_l = l;
  endtask

  task automatic new_run();
    armed     = 0;
    run_first = 1;
    run_cnt   = 0;
  endtask

  task automatic gen(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1;
      note_rise(h, l);
      repeat (h) @(negedge clk);
      sig_in = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      last_mv_cyc = cyc;
      if (q.size() == 0) begin
        check("unexp_mv", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("period", period, e.per);
        check("high_time", high_time, e.hi);
        check("locked", locked, e.lk);
        check("timeout_mv", timeout, 0);
        check("latency", cyc, e.at);
        last_per = e.per;
        last_hi  = e.hi;
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    #12;
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_mv", meas_valid, 0);
    check("rst_lock", locked, 0);
    check("rst_to", timeout, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) enable = 1'b1;
    @(negedge clk);

    gen(2, 2, 8);          // clk/4, lock on 4th measurement
    gen(3, 7, 6);          // clk/10 at 30% duty
    gen(2, 2, 6);
    gen(3, 3, 6);          // switch to clk/6 drops lock, then relocks

    gen(2, 2, 5);          // lock then stall low
    for (int i = 0; i < 400 && !timeout; i++) @(negedge clk);
    check("to_set", timeout, 1);
    check("to_lat", cyc - last_mv_cyc, 255);
    check("to_lock", locked, 0);
    new_run();
    repeat (5) @(negedge clk);
    check("to_sticky", timeout, 1);
    gen(2, 2, 6);
    check("to_clear", timeout, 0);

    gen(100, 155, 2);      // period exactly at counter ceiling
    gen(2, 2, 2);
    check("sat_no_to", timeout, 0);

    gen(2, 2, 6);
    check("pre_dis_lock", locked, 1);
    enable = 1'b0;
    q.delete();
    @(negedge clk);
    check("dis_lock", locked, 0);
    check("dis_mv", meas_valid, 0);
    check("dis_per", period, last_per);
    check("dis_high", high_time, last_hi);
    enable = 1'b1;
    new_run();
    @(negedge clk);

    gen(2, 2, 3);
    sig_in = 1'b1;
    note_rise(2, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", period, 0);
    check("arst_high", high_time, 0);
    check("arst_mv", meas_valid, 0);
    check("arst_lock", locked, 0);
    check("arst_to", timeout, 0);
    q.delete();
    new_run();
    @(negedge clk);
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gen(2, 2, 4);

    repeat (10) @(negedge clk);
    check("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_ratio_meter.md
DIV_RATIO_METER -- requirements
Module: div_ratio_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period/high-time counters.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (min 2).
REQ-003 SHALL have parameter STABLE_N, default 4, consecutive equal periods required for lock.
REQ-004 SHALL have port clk  input  1  reference clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sig_in  input  1  divided clock under measurement, asynchronous to clk.
REQ-007 SHALL have port enable  input  1  measurement enable, synchronous.
REQ-008 SHALL have port period  output  CNT_W  last measured rise-to-rise interval, clk cycles.
REQ-009 SHALL have port high_time  output  CNT_W  last measured rise-to-fall interval, clk cycles.
REQ-010 SHALL have port meas_valid  output  1  one-cycle pulse on period/high_time update.
REQ-011 SHALL have port locked  output  1  STABLE_N consecutive equal periods seen.
REQ-012 SHALL have port timeout  output  1  sticky flag, no rising edge within counter range.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops; rise/fall SHALL be detected from synchronized value vs its one-cycle-delayed copy.
REQ-014 FSM states SHALL be IDLE, WAIT_FIRST, MEASURE.
REQ-015 IDLE -> WAIT_FIRST when enable=1; any state -> IDLE when enable=0.
REQ-016 WAIT_FIRST -> MEASURE on first rise; falls in WAIT_FIRST SHALL be ignored.
REQ-017 Counter cnt SHALL load 1 on a rise cycle, else increment, saturating at 2^CNT_W-1.
REQ-018 On rise in MEASURE: period <= cnt, meas_valid <= 1 for exactly one cycle.
REQ-019 On fall in MEASURE: high_time staging register <= cnt; high_time output SHALL update together with period at the next rise.
REQ-020 Latency sig_in rising -> meas_valid high SHALL be SYNC_STAGES+1 clk edges.
REQ-021 Lock counter SHALL increment when a new period equals the previous one, reset to 1 on mismatch; locked=1 when count >= STABLE_N, cleared in the same cycle a mismatch is registered.
REQ-022 First measurement after WAIT_FIRST SHALL count as 1 toward lock.
REQ-023 cnt reaching 2^CNT_W-1 in MEASURE without a rise: timeout <= 1, locked <= 0, lock count <= 0, state -> WAIT_FIRST, no meas_valid.
REQ-024 Rise and saturation in the same cycle: rise SHALL win; no timeout.
REQ-025 timeout SHALL clear on next meas_valid or when enable=0.
REQ-026 enable=0: meas_valid, locked, timeout, lock count cleared next edge; period/high_time hold.
REQ-027 Fall with no fall since last rise (period with no high phase seen, e.g. sig_in glitch-free assumption violated) is not possible; rise without intervening fall SHALL report high_time = period.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, cnt 0, synchronizer flops 0, period 0, high_time 0, meas_valid 0, locked 0, timeout 0, lock count 0.
REQ-029 Reset release mid-waveform SHALL restart from IDLE; no measurement reported before two rises seen post-reset.

Structure
REQ-030 Package div_meas_pkg SHALL hold the FSM state type and default CNT_W/STABLE_N constants.
REQ-031 Sub-module edge_sync SHALL implement synchronizer plus rise/fall pulse generation.
REQ-032 All outputs SHALL be registered; no combinational path from sig_in to any output.

Verification
REQ-033 sig_in = clk/4 (toggle every 2 clks), enable=1 -> period=4, high_time=2, meas_valid every 4 clks, locked after 4th meas_valid.
REQ-034 sig_in = clk/10, 30% duty (3 high, 7 low) -> period=10, high_time=3, locked after 4th measurement.
REQ-035 Locked at clk/4, switch to clk/6 -> first period=6 clears locked same cycle as meas_valid; relock after 4 periods of 6.
REQ-036 CNT_W=8, sig_in stuck low after lock -> timeout=1 and locked=0 at cnt=255; resume clk/4 -> timeout clears on next meas_valid.
REQ-037 rst_n asserted mid high phase -> all outputs 0 immediately; after release, first meas_valid only after second rise.
REQ-038 enable dropped while locked -> locked=0, meas_valid=0 next edge, period holds last value.
